// File: rtl/m_wb_uart.sv
// Wishbone byte UART: 1-cycle ACK except DATA writes, which stall while TX is busy; 10*DIVISOR-cycle frames.
// `define UART_RX_FIFO_EN for an RXDEPTH-entry RX FIFO; otherwise RX uses a single holding register.
module m_wb_uart #(
  parameter int DIVISOR = 104,
  parameter int DIVW    = 16
`ifdef UART_RX_FIFO_EN
  , parameter int RXDEPTH = 4
`endif
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic        ADR_I,
  input  logic [7:0]  DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  input  logic        usartRX,
  output logic        usartTX
);

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam logic [DIVW-1:0] BIT_RELOAD  = DIVW'(DIVISOR - 1);
  localparam logic [DIVW-1:0] HALF_RELOAD = DIVW'(DIVISOR / 2);

  tx_state_t       tx_state;
  logic [8:0]      tx_shift;
  logic [3:0]      tx_bits;
  logic [DIVW-1:0] tx_cnt;
  logic            txbusy;

  rx_state_t       rx_state;
  logic            rx_meta, rx_sync, rx_prev;
  logic [DIVW-1:0] rx_cnt;
  logic [2:0]      rx_bits;
  logic [7:0]      rx_byte;
  logic            rx_push, rx_ferr, rx_drop, rx_pop;
  logic            rxavail;
  logic [7:0]      rx_head;
  logic            ovr, ferr;

  logic data_wr, data_rd, stat_rd;

  assign txbusy  = (tx_state == TX_SHIFT);
  assign ACK_O   = STB_I & ~(WE_I & ~ADR_I & txbusy);
  assign data_wr = ACK_O & WE_I & ~ADR_I;
  assign data_rd = ACK_O & ~WE_I & ~ADR_I;
  assign stat_rd = ACK_O & ~WE_I & ADR_I;
  assign rx_pop  = data_rd & rxavail;

  always_comb begin
    DAT_O = '0;
    if (data_rd)
      DAT_O = {23'b0, rxavail, rxavail ? rx_head : 8'h00};
    else if (stat_rd)
      DAT_O = {28'b0, ferr, ovr, rxavail, txbusy};
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      tx_state <= TX_IDLE;
      tx_shift <= '1;
      tx_bits  <= '0;
      tx_cnt   <= '0;
      usartTX  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (data_wr) begin
            tx_state <= TX_SHIFT;
            tx_shift <= {1'b1, DAT_I};
            tx_bits  <= 4'd9;
            tx_cnt   <= BIT_RELOAD;
            usartTX  <= 1'b0;
          end
        end
        TX_SHIFT: begin
          if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - 1'b1;
            // Leave SHIFT in the last stop-bit cycle so a stalled write starts the next frame with no gap.
            if (tx_bits == 4'd0 && tx_cnt == DIVW'(1))
              tx_state <= TX_IDLE;
          end else begin
            tx_cnt   <= BIT_RELOAD;
            tx_bits  <= tx_bits - 1'b1;
            usartTX  <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[8:1]};
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= usartRX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_byte  <= '0;
      rx_push  <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      rx_ferr <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= HALF_RELOAD;
          end
        end
        RX_START: begin
          if (rx_cnt != '0)
            rx_cnt <= rx_cnt - 1'b1;
          else if (rx_sync)
            rx_state <= RX_IDLE;
          else begin
            rx_state <= RX_DATA;
            rx_cnt   <= BIT_RELOAD;
            rx_bits  <= '0;
          end
        end
        RX_DATA: begin
          if (rx_cnt != '0)
            rx_cnt <= rx_cnt - 1'b1;
          else begin
            rx_byte <= {rx_sync, rx_byte[7:1]};
            rx_cnt  <= BIT_RELOAD;
            rx_bits <= rx_bits + 1'b1;
            if (rx_bits == 3'd7)
              rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_cnt != '0)
            rx_cnt <= rx_cnt - 1'b1;
          else begin
            // Back to IDLE at mid stop bit so the next start edge is caught early.
            rx_state <= RX_IDLE;
            if (rx_sync)
              rx_push <= 1'b1;
            else
              rx_ferr <= 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  logic fifo_rdy;

  m_wb_uart_fifo #(.DW(8), .DEPTH(RXDEPTH)) u_rx_fifo (
    .clk    (CLK_I),
    .rst    (RST_I),
    .wr_vld (rx_push),
    .wr_rdy (fifo_rdy),
    .wr_dat (rx_byte),
    .rd_vld (rxavail),
    .rd_rdy (rx_pop),
    .rd_dat (rx_head)
  );

  assign rx_drop = rx_push & ~fifo_rdy;
`else
  logic       hold_vld;
  logic [7:0] hold_dat;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      hold_vld <= 1'b0;
      hold_dat <= '0;
    end else if (rx_push && (!hold_vld || rx_pop)) begin
      hold_vld <= 1'b1;
      hold_dat <= rx_byte;
    end else if (rx_pop) begin
      hold_vld <= 1'b0;
    end
  end

  assign rxavail = hold_vld;
  assign rx_head = hold_dat;
  assign rx_drop = rx_push & hold_vld & ~rx_pop;
`endif

  // A new error event outranks a clearing STATUS read in the same cycle.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      ovr  <= rx_drop | (ovr & ~stat_rd);
      ferr <= rx_ferr | (ferr & ~stat_rd);
    end
  end

endmodule

`ifdef UART_RX_FIFO_EN
module m_wb_uart_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_vld,
  output logic          wr_rdy,
  input  logic [DW-1:0] wr_dat,
  output logic          rd_vld,
  input  logic          rd_rdy,
  output logic [DW-1:0] rd_dat
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_wr, do_rd;

  assign rd_vld = (count != '0);
  assign do_rd  = rd_vld & rd_rdy;
  // A same-cycle pop frees a slot, so a full FIFO still accepts the write.
  assign wr_rdy = (count != (AW+1)'(DEPTH)) | do_rd;
  assign do_wr  = wr_vld & wr_rdy;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_rd)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

endmodule
`endif

// File: tb/tb_m_wb_uart.sv
// Bench for m_wb_uart: directed sequence with random bytes, checked against a queue-based
// model of the register map and against bit-level frame timing derived from the byte values.
module tb_m_wb_uart;

  localparam int DIV = 104;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic        CLK_I = 1'b0;
  logic        RST_I, STB_I, WE_I, ADR_I;
  logic [7:0]  DAT_I;
  logic [31:0] DAT_O;
  logic        ACK_O;
  logic        usartRX, usartTX;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovr = 1'b0;
  logic       exp_ferr = 1'b0;

  m_wb_uart dut (
    .CLK_I   (CLK_I),
    .RST_I   (RST_I),
    .STB_I   (STB_I),
    .WE_I    (WE_I),
    .ADR_I   (ADR_I),
    .DAT_I   (DAT_I),
    .DAT_O   (DAT_O),
    .ACK_O   (ACK_O),
    .usartRX (usartRX),
    .usartTX (usartTX)
  );

  always #5 CLK_I = ~CLK_I;
  always @(posedge CLK_I) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // One bus access, started just after a falling edge; returns after the accepting rising edge.
  task automatic wb(input logic we, input logic adr, input logic [7:0] d,
                    output logic [31:0] rdat, output int waited, output int ack_cyc);
    STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = d;
    waited = 0;
    #1;
    while (ACK_O !== 1'b1 && waited < 3000) begin
      @(negedge CLK_I); #1;
      waited++;
    end
    check("ack_seen", {31'b0, ACK_O}, 32'd1);
    rdat = DAT_O;
    ack_cyc = cyc;
    @(negedge CLK_I);
    STB_I = 1'b0; WE_I = 1'b0; ADR_I = 1'b0; DAT_I = 8'h00;
  endtask

  task automatic rd_status(input string tag, input logic txb);
    logic [31:0] r;
    int w, c;
    wb(1'b0, 1'b1, 8'h00, r, w, c);
    check(tag, r, {28'b0, exp_ferr, exp_ovr, exp_q.size() != 0, txb});
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] r, e;
    int w, c;
    wb(1'b0, 1'b0, 8'h00, r, w, c);
    if (exp_q.size() != 0) e = {23'b0, 1'b1, exp_q.pop_front()};
    else e = 32'h0;
    check(tag, r, e);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      usartRX = f[i];
      repeat (DIV) @(negedge CLK_I);
    end
    usartRX = 1'b1;
    if (!stop) exp_ferr = 1'b1;
    else if (exp_q.size() < CAP) exp_q.push_back(b);
    else exp_ovr = 1'b1;
  endtask

  // Each bit must hold its value for exactly DIV consecutive falling-edge samples.
  task automatic tx_mon(input logic [19:0] bits, input int nbits);
    int hits;
    for (int b = 0; b < nbits; b++) begin
      hits = 0;
      for (int c = 0; c < DIV; c++) begin
        if (usartTX === bits[b]) hits++;
        @(negedge CLK_I);
      end
      check($sformatf("tx_bit%0d", b), hits, DIV);
    end
  endtask

  initial begin
    logic [31:0] r;
    int w, w2, c1, c2;
    logic [7:0] b, b2;

    RST_I = 1'b1; STB_I = 1'b0; WE_I = 1'b0; ADR_I = 1'b0; DAT_I = 8'h00; usartRX = 1'b1;
    repeat (3) @(negedge CLK_I);
    RST_I = 1'b0;
    #1;
    check("rst_tx", {31'b0, usartTX}, 32'd1);
    check("rst_ack", {31'b0, ACK_O}, 32'd0);
    check("rst_dat", DAT_O, 32'h0);
    @(negedge CLK_I);
    rd_status("rst_status", 1'b0);
    rd_data("rst_data");
    wb(1'b1, 1'b1, 8'hFF, r, w, c1);
    check("stat_wr_wait", w, 0);
    rd_status("stat_wr_ignored", 1'b0);

    // Single frame 0x55 with busy flag observed during and after the frame
    wb(1'b1, 1'b0, 8'h55, r, w, c1);
    check("t1_wait", w, 0);
    fork
      tx_mon({10'h3FF, frame(8'h55)}, 10);
      begin
        rd_status("t1_busy_first", 1'b1);
        repeat (1036) @(negedge CLK_I);
        rd_status("t1_busy_late", 1'b1);
      end
    join
    check("t1_idle_line", {31'b0, usartTX}, 32'd1);
    rd_status("t1_busy_clear", 1'b0);

    // Back-to-back writes: second ACK 1040 cycles after the first, frames contiguous
    wb(1'b1, 1'b0, 8'hA5, r, w, c1);
    fork
      tx_mon({frame(8'h3C), frame(8'hA5)}, 20);
      wb(1'b1, 1'b0, 8'h3C, r, w2, c2);
    join
    check("t2_ack_gap", c2 - c1, 1040);
    check("t2_idle_line", {31'b0, usartTX}, 32'd1);
    rd_status("t2_busy_clear", 1'b0);

    // Random TX byte
    b = 8'($urandom);
    wb(1'b1, 1'b0, b, r, w, c1);
    tx_mon({10'h3FF, frame(b)}, 10);

    // RX of 0xC3, then empty read
    rx_frame(8'hC3, 1'b1);
    repeat (5) @(negedge CLK_I);
    rd_status("t3_status", 1'b0);
    rd_data("t3_data");
    rd_data("t3_empty");

    // False start and framing error
    usartRX = 1'b0;
    repeat (40) @(negedge CLK_I);
    usartRX = 1'b1;
    repeat (200) @(negedge CLK_I);
    rd_status("t4_glitch", 1'b0);
    rx_frame(8'($urandom), 1'b0);
    repeat (20) @(negedge CLK_I);
    rd_status("t4_ferr", 1'b0);
    rd_status("t4_ferr_cleared", 1'b0);
    rd_data("t4_no_byte");

    // Overflow: CAP+1 frames with random gaps, no reads in between
    for (int i = 0; i <= CAP; i++) begin
      rx_frame(8'($urandom), 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge CLK_I);
    end
    repeat (5) @(negedge CLK_I);
    rd_status("t5_ovr", 1'b0);
    for (int i = 0; i <= CAP; i++) rd_data($sformatf("t5_read%0d", i));

    // Full buffer drained by a read while another frame arrives: no overflow
    for (int i = 0; i < CAP; i++) rx_frame(8'($urandom), 1'b1);
    b2 = 8'($urandom);
    fork
      rx_frame(b2, 1'b1);
      begin
        repeat (500) @(negedge CLK_I);
        rd_data("t5_pop_mid_frame");
      end
    join
    repeat (5) @(negedge CLK_I);
    rd_status("t5_no_ovr", 1'b0);
    for (int i = 0; i <= CAP; i++) rd_data($sformatf("t5_drain%0d", i));

    // Reset in the middle of a TX frame
    b = 8'($urandom) & 8'hEF;
    wb(1'b1, 1'b0, b, r, w, c1);
    repeat (520) @(negedge CLK_I);
    check("t6_mid_frame_low", {31'b0, usartTX}, 32'd0);
    RST_I = 1'b1;
    @(negedge CLK_I);
    RST_I = 1'b0;
    exp_q.delete();
    exp_ovr = 1'b0;
    exp_ferr = 1'b0;
    check("t6_tx_high", {31'b0, usartTX}, 32'd1);
    rd_status("t6_status", 1'b0);
    b = 8'($urandom);
    wb(1'b1, 1'b0, b, r, w, c1);
    check("t6_write_wait", w, 0);
    tx_mon({10'h3FF, frame(b)}, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
